wb_tube_wbuf: RTL

//  Posted-write buffer between the ARM2 Wishbone master and the Tube Wishbone controller.

---
 rtl/wb_tube_wbuf_pkg.sv | 39 +++
 rtl/wb_tube_wbuf_fifo.sv | 69 ++++++
 rtl/wb_tube_wbuf.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wb_tube_wbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_tube_wbuf_pkg : shared types for the Tube posted-write buffer           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wb_tube_wbuf_pkg;

  localparam int c_adr_w   = 3;
  localparam int c_sel_w   = 4;
  localparam int c_dat_w   = 32;
  localparam int c_entry_w = c_adr_w + c_sel_w + c_dat_w;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } mstate_t;

  // Packed so that adr sits in [2:0], sel in [6:3] and dat in [38:7].
  typedef struct packed {
    logic [c_dat_w-1:0] dat;
    logic [c_sel_w-1:0] sel;
    logic [c_adr_w-1:0] adr;
  } wbuf_entry_t;

  function automatic wbuf_entry_t make_entry(
    input logic [c_adr_w-1:0] adr,
    input logic [c_sel_w-1:0] sel,
    input logic [c_dat_w-1:0] dat
  );
    wbuf_entry_t e;
    e.adr = adr;
    e.sel = sel;
    e.dat = dat;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_tube_wbuf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_tube_wbuf_fifo : synchronous FIFO with a combinational head output      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_tube_wbuf_fifo
  import wb_tube_wbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  wbuf_entry_t         din,
  output wbuf_entry_t         dout,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int                  c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_level = {1'b1, {DEPTH_LOG2{1'b0}}};

  wbuf_entry_t             r_mem [c_depth];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic                    w_do_push;
  logic                    w_do_pop;

  assign empty = (r_level == '0);
  assign full  = (r_level == c_full_level);

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/wb_tube_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_tube_wbuf : posted-write buffer between the ARM2 master and the Tube    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_tube_wbuf
  import wb_tube_wbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_stb_i,
  input  logic                 s_cyc_i,
  input  logic                 s_we_i,
  input  logic [c_adr_w-1:0]   s_adr_i,
  input  logic [c_sel_w-1:0]   s_sel_i,
  input  logic [c_dat_w-1:0]   s_dat_i,
  output logic                 s_ack_o,
  output logic [c_dat_w-1:0]   s_dat_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [c_adr_w-1:0]   m_adr_o,
  output logic [c_sel_w-1:0]   m_sel_o,
  output logic [c_dat_w-1:0]   m_dat_o,
  input  logic                 m_ack_i,
  input  logic [c_dat_w-1:0]   m_dat_i,
  output logic [DEPTH_LOG2:0]  wbuf_level
);

  mstate_t              r_state;
  mstate_t              w_state_nxt;

  logic                 r_cyc;
  logic                 r_we;
  logic [c_adr_w-1:0]   r_adr;
  logic [c_sel_w-1:0]   r_sel;
  logic [c_dat_w-1:0]   r_mdat;
  logic                 r_s_ack;
  logic [c_dat_w-1:0]   r_s_dat;

  logic                 w_cyc_nxt;
  logic                 w_we_nxt;
  logic [c_adr_w-1:0]   w_adr_nxt;
  logic [c_sel_w-1:0]   w_sel_nxt;
  logic [c_dat_w-1:0]   w_mdat_nxt;
  logic                 w_s_ack_nxt;
  logic [c_dat_w-1:0]   w_s_dat_nxt;

  logic                 w_s_wr;
  logic                 w_s_rd;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  wbuf_entry_t          w_head;
  wbuf_entry_t          w_din;

  // Masking with the registered ack keeps a held strobe from being taken twice.
  assign w_s_wr = s_stb_i & s_cyc_i &  s_we_i & ~r_s_ack;
  assign w_s_rd = s_stb_i & s_cyc_i & ~s_we_i & ~r_s_ack;

  assign w_pop  = (r_state == M_WRITE) & m_ack_i;
  assign w_push = w_s_wr & (~w_full | w_pop);
  assign w_din  = make_entry(s_adr_i, s_sel_i, s_dat_i);

  wb_tube_wbuf_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .level (wbuf_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_adr_nxt   = r_adr;
    w_sel_nxt   = r_sel;
    w_mdat_nxt  = r_mdat;
    w_s_dat_nxt = r_s_dat;
    w_s_ack_nxt = w_push;

    case (r_state)
      M_IDLE: begin
        // Queued writes drain first, so a read never overtakes a posted write.
        if (!w_empty) begin
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_adr_nxt   = w_head.adr;
          w_sel_nxt   = w_head.sel;
          w_mdat_nxt  = w_head.dat;
          w_state_nxt = M_WRITE;
        end else if (w_s_rd) begin
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_adr_nxt   = s_adr_i;
          w_sel_nxt   = s_sel_i;
          w_state_nxt = M_READ;
        end
      end
      M_WRITE: begin
        if (m_ack_i) begin
          w_cyc_nxt   = 1'b0;
          w_state_nxt = M_IDLE;
        end
      end
      M_READ: begin
        if (m_ack_i) begin
          w_cyc_nxt   = 1'b0;
          w_s_dat_nxt = m_dat_i;
          w_s_ack_nxt = 1'b1;
          w_state_nxt = M_IDLE;
        end
      end
      default: begin
        w_cyc_nxt   = 1'b0;
        w_state_nxt = M_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= M_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_mdat  <= '0;
      r_s_ack <= 1'b0;
      r_s_dat <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_we    <= w_we_nxt;
      r_adr   <= w_adr_nxt;
      r_sel   <= w_sel_nxt;
      r_mdat  <= w_mdat_nxt;
      r_s_ack <= w_s_ack_nxt;
      r_s_dat <= w_s_dat_nxt;
    end
  end

  assign s_ack_o = r_s_ack;
  assign s_dat_o = r_s_dat;
  assign m_cyc_o = r_cyc;
  assign m_stb_o = r_cyc;
  assign m_we_o  = r_we;
  assign m_adr_o = r_adr;
  assign m_sel_o = r_sel;
  assign m_dat_o = r_mdat;

endmodule
`default_nettype wire
